can_tx: RTL and testbench
=========================

# can_tx

CAN 2.0A (standard, 11-bit ID) frame transmitter: the transmit-side counterpart of `can_rx`/`can_destuff`. It latches a frame request and computes CRC-15. It serialises SOF through EOF and intermission onto `o_Tx_Serial`, with NRZ bit stuffing. Each bit is held for `CLKS_PER_BIT` clocks, so the output can be looped straight into `can_destuff` and `can_rx` benches.

## Interface
- `CLKS_PER_BIT`, 10, clocks per CAN bit time (≥2).
- `i_Clock`  in  1  system clock; all logic on rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Tx_DV`  in  1  frame request; sampled only in IDLE.
- `i_Id`  in  11  identifier, bit 10 sent first.
- `i_Rtr`  in  1  remote request flag.
- `i_Dlc`  in  4  data length code, sent as given.
- `i_Data`  in  64  payload; byte 0 = `[63:56]`, MSB first.
- `o_Tx_Serial`  out  1  bus bit; 1 = recessive.
- `o_Tx_Active`  out  1  high from SOF through last intermission bit.
- `o_Tx_Done`  out  1  one-cycle pulse at frame end.
- `o_Stuff_Bit`  out  1  high for the full bit time of every inserted stuff bit.

## Operation
- IDLE: `o_Tx_Serial`=1. On `i_Tx_DV`=1, latch `i_Id`, `i_Rtr`, `i_Dlc`, `i_Data`; clear CRC and stuff counter; go to SOF.
- States and unstuffed bit counts:
  - SOF: 1, value 0.
  - ARB: 12, ID[10:0] then RTR.
  - CTRL: 6, IDE=0, r0=0, DLC[3:0].
  - DATA: 8·N bits, where N=0 if RTR=1, else min(DLC,8). Skipped if N=0.
  - CRC: 15, crc[14:0] MSB first.
  - CRC_DEL: 1, value 1.
  - ACK: 1, value 1 (slot is sent recessive).
  - ACK_DEL: 1, value 1.
  - EOF: 7, value 1.
  - IFS: 3, value 1.
  - Then back to IDLE.
- CRC-15 runs over unstuffed bits SOF..last DATA bit. Per bit b: `n = b ^ crc[14]`; `crc = {crc[13:0],1'b0} ^ (n ? 15'h4599 : 0)`. Init 0.
- Stuffing applies to SOF..last CRC bit:
  - Track the last bit value and a run count (1..5).
  - After 5 equal consecutive bits, insert one bit of opposite value before the next data bit, with `o_Stuff_Bit`=1.
  - A stuff bit resets the run to count 1 with the stuff value.
  - If the 5th equal bit is the last CRC bit, the stuff bit is still inserted before CRC_DEL.
  - Stuff bits do not enter the CRC.
- `i_Tx_DV` and input changes while `o_Tx_Active`=1 are ignored; the latched frame is sent unchanged.
- No arbitration-loss or ACK-error detection; the bus is not monitored.

## Timing
- Reset values: `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, `o_Stuff_Bit`=0. State is IDLE; counters and CRC are 0.
- Reset mid-frame takes effect on the next edge: output goes recessive, no `o_Tx_Done`, and the frame is dropped.
- Start latency: `i_Tx_DV` high at edge k → SOF is on `o_Tx_Serial` and `o_Tx_Active`=1 from edge k+1.
- Each bit, stuffed or not, is stable for exactly `CLKS_PER_BIT` clocks; bit-clock counter runs 0..CLKS_PER_BIT-1.
- Frame length = 47 + 8N + S bits, where S = number of stuff bits. Total = that × `CLKS_PER_BIT` clocks.
- `o_Tx_Done` pulses during the last clock of the final IFS bit. `o_Tx_Active` drops on the following edge.
- A new `i_Tx_DV` is accepted on the first IDLE clock after `o_Tx_Active` falls. `i_Tx_DV` held high → back-to-back frames with no extra idle bits.
- `o_Stuff_Bit` is aligned exactly with the stuff bit on `o_Tx_Serial`.

## Test plan
- Reset: assert `i_Reset` for 3 clocks with `i_Tx_DV`=1 → all outputs at reset values; transmission starts 1 clock after release.
- ID=0x000, RTR=0, DLC=0:
  - 34 unstuffed zeros; CRC=0x0000.
  - Stuff 1s after zeros #5, #10, #15, #20, #25, #30 (6 pulses of `o_Stuff_Bit`).
  - Then 13 recessive bits.
  - Total 53 bits = 530 clocks; `o_Tx_Done` at clock 530.
- ID=0x7FF, RTR=0, DLC=1, data=0xFF:
  - First stuff bit (0) follows SOF + ID[10:6].
  - The whole frame's CRC and stuff positions match a bit-accurate software model.
  - Looping `o_Tx_Serial` into `can_destuff` yields `o_Eror_Stuffing`=0 for the whole frame.
- DLC=9, RTR=0: exactly 64 data bits sent, and the DLC field shows 1001. Separately, RTR=1 with DLC=8: no data bits sent, length 47+S.
- Pulse `i_Tx_DV` with new ID mid-frame: the frame in progress is unchanged and no second frame starts. Then hold `i_Tx_DV` high → second SOF on the clock after `o_Tx_Active` falls.
- Assert `i_Reset` during the DATA state → `o_Tx_Serial`=1 on the next clock, no `o_Tx_Done`; the next request sends a complete, correct frame.

Source files
------------

// File: rtl/can_tx.sv
`default_nettype none
// ============================================================================
// Module      : can_tx
// Description : CAN 2.0A standard-frame transmitter with CRC-15 and NRZ
//               bit stuffing; each bus bit is held for CLKS_PER_BIT clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module can_tx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Tx_DV,
    input  logic [10:0] i_Id,
    input  logic        i_Rtr,
    input  logic [3:0]  i_Dlc,
    input  logic [63:0] i_Data,
    output logic        o_Tx_Serial,
    output logic        o_Tx_Active,
    output logic        o_Tx_Done,
    output logic        o_Stuff_Bit
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [3:0] c_S_IDLE    = 4'd0;
    localparam logic [3:0] c_S_SOF     = 4'd1;
    localparam logic [3:0] c_S_ARB     = 4'd2;
    localparam logic [3:0] c_S_CTRL    = 4'd3;
    localparam logic [3:0] c_S_DATA    = 4'd4;
    localparam logic [3:0] c_S_CRC     = 4'd5;
    localparam logic [3:0] c_S_CRC_DEL = 4'd6;
    localparam logic [3:0] c_S_ACK     = 4'd7;
    localparam logic [3:0] c_S_ACK_DEL = 4'd8;
    localparam logic [3:0] c_S_EOF     = 4'd9;
    localparam logic [3:0] c_S_IFS     = 4'd10;

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [5:0]       r_bit_cnt;
    logic             r_stuff_active;
    logic             r_run_val;
    logic [2:0]       r_run_cnt;
    logic [14:0]      r_crc;
    logic [10:0]      r_id;
    logic             r_rtr;
    logic [3:0]       r_dlc;
    logic [63:0]      r_data;
    logic [3:0]       r_nbytes;

    logic             w_bit_end;
    logic [5:0]       w_last_idx;
    logic             w_field_last;
    logic             w_bit;
    logic             w_crc_region;
    logic             w_stuff_region;
    logic [3:0]       w_arb_idx;
    logic [1:0]       w_ctl_idx;
    logic [3:0]       w_crc_idx;
    logic             w_crc_fb;
    logic [14:0]      w_crc_next;
    logic [2:0]       w_run_cnt_next;

    assign w_bit_end    = (r_clk_cnt == c_CLK_LAST);
    assign w_field_last = (r_bit_cnt == w_last_idx);
    assign w_arb_idx    = 4'd10 - r_bit_cnt[3:0];
    assign w_ctl_idx    = 2'd1 - r_bit_cnt[1:0];
    assign w_crc_idx    = 4'd14 - r_bit_cnt[3:0];

    assign w_crc_region   = (r_state == c_S_SOF) || (r_state == c_S_ARB) ||
                            (r_state == c_S_CTRL) || (r_state == c_S_DATA);
    assign w_stuff_region = w_crc_region || (r_state == c_S_CRC);

    assign w_crc_fb       = w_bit ^ r_crc[14];
    assign w_crc_next     = {r_crc[13:0], 1'b0} ^ (w_crc_fb ? 15'h4599 : 15'h0000);
    assign w_run_cnt_next = ((r_run_cnt != 3'd0) && (w_bit == r_run_val)) ?
                            r_run_cnt + 3'd1 : 3'd1;

    always_comb begin
        w_last_idx = 6'd0;
        case (r_state)
            c_S_ARB:  w_last_idx = 6'd11;
            c_S_CTRL: w_last_idx = 6'd5;
            c_S_DATA: w_last_idx = 6'({r_nbytes, 3'b000} - 7'd1);
            c_S_CRC:  w_last_idx = 6'd14;
            c_S_EOF:  w_last_idx = 6'd6;
            c_S_IFS:  w_last_idx = 6'd2;
            default:  w_last_idx = 6'd0;
        endcase
    end

    // Unstuffed value of the current field bit; fixed-form fields are recessive.
    always_comb begin
        w_bit = 1'b1;
        case (r_state)
            c_S_SOF:  w_bit = 1'b0;
            c_S_ARB:  w_bit = (r_bit_cnt == 6'd11) ? r_rtr : r_id[w_arb_idx];
            c_S_CTRL: w_bit = (r_bit_cnt < 6'd2) ? 1'b0 : r_dlc[w_ctl_idx];
            c_S_DATA: w_bit = r_data[~r_bit_cnt];
            c_S_CRC:  w_bit = r_crc[w_crc_idx];
            default:  w_bit = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fields advance only at the end of a data bit; a pending stuff bit holds them.
    always_comb begin
        w_next_state = r_state;
        if (r_state == c_S_IDLE) begin
            if (i_Tx_DV) begin
                w_next_state = c_S_SOF;
            end
        end else if (w_bit_end && !r_stuff_active && w_field_last) begin
            case (r_state)
                c_S_SOF:     w_next_state = c_S_ARB;
                c_S_ARB:     w_next_state = c_S_CTRL;
                c_S_CTRL:    w_next_state = (r_nbytes == 4'd0) ? c_S_CRC : c_S_DATA;
                c_S_DATA:    w_next_state = c_S_CRC;
                c_S_CRC:     w_next_state = c_S_CRC_DEL;
                c_S_CRC_DEL: w_next_state = c_S_ACK;
                c_S_ACK:     w_next_state = c_S_ACK_DEL;
                c_S_ACK_DEL: w_next_state = c_S_EOF;
                c_S_EOF:     w_next_state = c_S_IFS;
                c_S_IFS:     w_next_state = c_S_IDLE;
                default:     w_next_state = c_S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_Tx_Serial = 1'b1;
        o_Tx_Active = 1'b0;
        o_Tx_Done   = 1'b0;
        o_Stuff_Bit = 1'b0;
        if (r_state != c_S_IDLE) begin
            o_Tx_Active = 1'b1;
            o_Tx_Serial = r_stuff_active ? ~r_run_val : w_bit;
            o_Stuff_Bit = r_stuff_active;
            o_Tx_Done   = (r_state == c_S_IFS) && w_field_last && w_bit_end;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_clk_cnt      <= '0;
            r_bit_cnt      <= 6'd0;
            r_stuff_active <= 1'b0;
            r_run_val      <= 1'b0;
            r_run_cnt      <= 3'd0;
            r_crc          <= 15'd0;
            r_id           <= 11'd0;
            r_rtr          <= 1'b0;
            r_dlc          <= 4'd0;
            r_data         <= 64'd0;
            r_nbytes       <= 4'd0;
        end else if (r_state == c_S_IDLE) begin
            r_clk_cnt      <= '0;
            r_bit_cnt      <= 6'd0;
            r_stuff_active <= 1'b0;
            r_run_cnt      <= 3'd0;
            r_crc          <= 15'd0;
            if (i_Tx_DV) begin
                r_id     <= i_Id;
                r_rtr    <= i_Rtr;
                r_dlc    <= i_Dlc;
                r_data   <= i_Data;
                r_nbytes <= i_Rtr ? 4'd0 : ((i_Dlc > 4'd8) ? 4'd8 : i_Dlc);
            end
        end else begin
            r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
            if (w_bit_end) begin
                if (r_stuff_active) begin
                    r_stuff_active <= 1'b0;
                    r_run_val      <= ~r_run_val;
                    r_run_cnt      <= 3'd1;
                end else begin
                    if (w_crc_region) begin
                        r_crc <= w_crc_next;
                    end
                    if (w_stuff_region) begin
                        r_run_val      <= w_bit;
                        r_run_cnt      <= w_run_cnt_next;
                        r_stuff_active <= (w_run_cnt_next == 3'd5);
                    end
                    r_bit_cnt <= w_field_last ? 6'd0 : r_bit_cnt + 6'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_can_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_can_tx
// Description : Directed scoreboard bench for can_tx against a bit-level
//               frame model (CRC-15 plus stuffing).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_tx;

    localparam int CPB = 10;

    typedef struct packed {
        logic ser;
        logic stf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_Tx_DV;
    logic [10:0] i_Id;
    logic        i_Rtr;
    logic [3:0]  i_Dlc;
    logic [63:0] i_Data;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;
    logic        o_Stuff_Bit;

    exp_t q_exp[$];
    int   n_vec;
    int   n_fail;

    can_tx #(.CLKS_PER_BIT(CPB)) u_dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Tx_DV     (i_Tx_DV),
        .i_Id        (i_Id),
        .i_Rtr       (i_Rtr),
        .i_Dlc       (i_Dlc),
        .i_Data      (i_Data),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Tx_Active (o_Tx_Active),
        .o_Tx_Done   (o_Tx_Done),
        .o_Stuff_Bit (o_Stuff_Bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference frame: raw bits, CRC over SOF..DATA, stuffing over SOF..CRC.
    task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                         input logic [63:0] data);
        logic raw[$];
        logic [14:0] crc;
        logic nxt;
        logic last;
        int   run;
        int   nbytes;
        int   nstuffable;
        exp_t e;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < 8 * nbytes; i++) raw.push_back(data[63 - i]);
        crc = 15'd0;
        foreach (raw[i]) begin
            nxt = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nxt) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        nstuffable = raw.size();
        last = 1'b0;
        run  = 0;
        for (int i = 0; i < nstuffable; i++) begin
            e.ser = raw[i];
            e.stf = 1'b0;
            q_exp.push_back(e);
            if (run > 0 && raw[i] == last) run++;
            else begin
                run  = 1;
                last = raw[i];
            end
            if (run == 5) begin
                e.ser = ~last;
                e.stf = 1'b1;
                q_exp.push_back(e);
                last = ~last;
                run  = 1;
            end
        end
        for (int i = 0; i < 13; i++) begin
            e.ser = 1'b1;
            e.stf = 1'b0;
            q_exp.push_back(e);
        end
    endtask

    task automatic start(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                         input logic [63:0] data);
        @(negedge clk);
        i_Id    = id;
        i_Rtr   = rtr;
        i_Dlc   = dlc;
        i_Data  = data;
        i_Tx_DV = 1'b1;
    endtask

    // Expects SOF on the next edge; checks every clock of the frame.
    task automatic check_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data, input int pulse_bit,
                               input bit keep_dv, input int exp_stuffs);
        exp_t e;
        int   bi;
        int   seen;
        build(id, rtr, dlc, data);
        bi   = 0;
        seen = 0;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                if (bi == 0 && j == 0) i_Tx_DV = keep_dv;
                if (bi == pulse_bit && j == 0) begin
                    i_Tx_DV = 1'b1;
                    i_Id    = ~i_Id;
                    i_Data  = ~i_Data;
                    i_Dlc   = 4'd2;
                end
                if (bi == pulse_bit && j == 1) i_Tx_DV = keep_dv;
                chk("serial", o_Tx_Serial, e.ser);
                chk("stuff", o_Stuff_Bit, e.stf);
                chk("active", o_Tx_Active, 1'b1);
                chk("done", o_Tx_Done, (q_exp.size() == 0 && j == CPB - 1));
                if (j == 0 && o_Stuff_Bit) seen++;
            end
            bi++;
        end
        if (exp_stuffs >= 0) chk("nstuff", seen, exp_stuffs);
        @(negedge clk);
        chk("end_active", o_Tx_Active, 1'b0);
        chk("end_serial", o_Tx_Serial, 1'b1);
        chk("end_done", o_Tx_Done, 1'b0);
    endtask

    initial begin
        n_vec   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        i_Tx_DV = 1'b1;
        i_Id    = 11'h000;
        i_Rtr   = 1'b0;
        i_Dlc   = 4'd0;
        i_Data  = 64'd0;

        // Reset held with a request pending, then all-dominant frame right after release
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_serial", o_Tx_Serial, 1'b1);
            chk("rst_active", o_Tx_Active, 1'b0);
            chk("rst_done", o_Tx_Done, 1'b0);
            chk("rst_stuff", o_Stuff_Bit, 1'b0);
        end
        rst = 1'b0;
        check_frame(11'h000, 1'b0, 4'd0, 64'd0, -1, 1'b0, 6);

        start(11'h7FF, 1'b0, 4'd1, 64'hFF00_0000_0000_0000);
        check_frame(11'h7FF, 1'b0, 4'd1, 64'hFF00_0000_0000_0000, -1, 1'b0, -1);

        start(11'h3A5, 1'b0, 4'd9, 64'h0123_4567_89AB_CDEF);
        check_frame(11'h3A5, 1'b0, 4'd9, 64'h0123_4567_89AB_CDEF, -1, 1'b0, -1);

        start(11'h0F0, 1'b1, 4'd8, 64'hFFFF_0000_FFFF_0000);
        check_frame(11'h0F0, 1'b1, 4'd8, 64'hFFFF_0000_FFFF_0000, -1, 1'b0, -1);

        // Mid-frame request with altered inputs must be ignored
        start(11'h123, 1'b0, 4'd2, 64'hA5C3_0000_0000_0000);
        check_frame(11'h123, 1'b0, 4'd2, 64'hA5C3_0000_0000_0000, 20, 1'b0, -1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("idle_active", o_Tx_Active, 1'b0);
        end

        // Request held high: second SOF on the edge after active falls
        start(11'h555, 1'b0, 4'd3, 64'h00FF_8100_0000_0000);
        check_frame(11'h555, 1'b0, 4'd3, 64'h00FF_8100_0000_0000, -1, 1'b1, -1);
        check_frame(11'h555, 1'b0, 4'd3, 64'h00FF_8100_0000_0000, -1, 1'b0, -1);

        // Reset during DATA drops the frame without a done pulse
        start(11'h2AA, 1'b0, 4'd8, 64'hDEAD_BEEF_0F1E_2D3C);
        for (int k = 0; k < 40 * CPB; k++) begin
            @(negedge clk);
            i_Tx_DV = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_serial", o_Tx_Serial, 1'b1);
        chk("mid_rst_active", o_Tx_Active, 1'b0);
        chk("mid_rst_done", o_Tx_Done, 1'b0);
        chk("mid_rst_stuff", o_Stuff_Bit, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("post_rst_done", o_Tx_Done, 1'b0);
            chk("post_rst_active", o_Tx_Active, 1'b0);
        end
        start(11'h2AA, 1'b0, 4'd8, 64'hDEAD_BEEF_0F1E_2D3C);
        check_frame(11'h2AA, 1'b0, 4'd8, 64'hDEAD_BEEF_0F1E_2D3C, -1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
